// File: rtl/rv32_isa_pkg.sv
// RV32IM opcode constants, decoded-field bundle and loader state encoding.
// Shared by the field encoder, the program loader and benches.
// Pure type/constant package: no logic, no latency, no flow control.
package rv32_isa_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  func3;
        logic [6:0]  func7;
        logic [11:0] imm;    // I/S: imm[11:0], B: imm[12:1]
        logic [19:0] imm20;  // U: imm[31:12], J: imm[20:1]
    } inst_fields_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} loader_state_e;

endpackage

// File: rtl/inst_field_encoder.sv
// Packs decoded RV32IM fields back into a 32-bit instruction word.
// Latency: combinational, zero cycles.
// Backpressure: none; fields absent from the format are forced to zero.
module inst_field_encoder
    import rv32_isa_pkg::*;
(
    input  inst_fields_t fields,
    output logic [31:0]  word,
    output logic         illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fields.opcode)
            OP_R:
                word = {fields.func7, fields.rs2, fields.rs1, fields.func3, fields.rd, fields.opcode};
            OP_IMM, OP_LOAD, OP_JALR:
                word = {fields.imm, fields.rs1, fields.func3, fields.rd, fields.opcode};
            OP_STORE:
                word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.func3,
                        fields.imm[4:0], fields.opcode};
            // imm holds offset[12:1], so the scatter is shifted by one bit
            OP_BRANCH:
                word = {fields.imm[11], fields.imm[9:4], fields.rs2, fields.rs1, fields.func3,
                        fields.imm[3:0], fields.imm[10], fields.opcode};
            OP_LUI, OP_AUIPC:
                word = {fields.imm20, fields.rd, fields.opcode};
            OP_JAL:
                word = {fields.imm20[19], fields.imm20[9:0], fields.imm20[10],
                        fields.imm20[18:11], fields.rd, fields.opcode};
            default:
                illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/inst_encoder_loader.sv
// Streams field beats into imem as encoded words at consecutive addresses; INST_ENCODER_CHECKSUM_EN adds an XOR checksum port.
// Latency: one registered stage from accepted beat to mem_we.
// Backpressure: in_ready drops once MAX_WORDS words are written; illegal beats are consumed without a write.
module inst_encoder_loader
    import rv32_isa_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [11:0]       Imm,
    input  logic [19:0]       Imm20,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              err_illegal,
    output logic              err_overflow
`ifdef INST_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_WORDS);

    loader_state_e     state, state_nxt;
    inst_fields_t      fields;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic [ADDR_W-1:0] ptr;
    logic              we_q;
    logic              full;
    logic              accept;

    assign fields.opcode = opcode;
    assign fields.rd     = rd;
    assign fields.rs1    = rs1;
    assign fields.rs2    = rs2;
    assign fields.func3  = func3;
    assign fields.func7  = func7;
    assign fields.imm    = Imm;
    assign fields.imm20  = Imm20;

    inst_field_encoder u_enc (
        .fields  (fields),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign full   = (word_count >= MAX_CNT);
    assign accept = in_valid & in_ready;
    // A write still in the output stage is dropped the moment reset is seen.
    assign mem_we = we_q & ~rst;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                in_ready = ~full;
                if (in_valid && (full || in_last)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            we_q         <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            word_count   <= '0;
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
`ifdef INST_ENCODER_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            state <= state_nxt;
            we_q  <= 1'b0;
            if (state == IDLE && start) begin
                ptr          <= base_addr;
                word_count   <= '0;
                err_illegal  <= 1'b0;
                err_overflow <= 1'b0;
`ifdef INST_ENCODER_CHECKSUM_EN
                checksum     <= '0;
`endif
            end
            if (accept) begin
                if (enc_illegal) begin
                    err_illegal <= 1'b1;
                end else begin
                    we_q       <= 1'b1;
                    mem_addr   <= ptr;
                    mem_wdata  <= enc_word;
                    ptr        <= ptr + 1'b1;
                    word_count <= word_count + 1'b1;
`ifdef INST_ENCODER_CHECKSUM_EN
                    checksum   <= checksum ^ enc_word;
`endif
                end
            end
            if (state == RUN && in_valid && full) err_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Scoreboard bench for inst_encoder_loader: randomized field beats against a reference
// model that encodes from true immediate values using the standard RV32 layouts.
module tb_inst_encoder_loader;

    localparam int ADDR_W    = 10;
    localparam int MAX_WORDS = 1024;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_last = 1'b0;
    logic [6:0]        opcode = '0;
    logic [4:0]        rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]        func3 = '0;
    logic [6:0]        func7 = '0;
    logic [11:0]       Imm = '0;
    logic [19:0]       Imm20 = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy, done;
    logic [ADDR_W:0]   word_count;
    logic              err_illegal, err_overflow;
`ifdef INST_ENCODER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .func3(func3), .func7(func7),
        .Imm(Imm), .Imm20(Imm20),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .word_count(word_count),
        .err_illegal(err_illegal), .err_overflow(err_overflow)
`ifdef INST_ENCODER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;    // the instruction's true immediate value
        logic [11:0] imm12;
        logic [19:0] imm20;
    } beat_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int wc; bit ill; bit ovf; logic [31:0] cks; } dn_t;

    wr_t   wq[$];
    dn_t   dq[$];
    beat_t dir[$];
    wr_t   mon_w;
    dn_t   mon_d;
    int    errors = 0;
    int    checks = 0;

    logic [ADDR_W-1:0] maddr;
    int                mcount;
    bit                mill, movf;
    logic [31:0]       mcks;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, -1 unsupported
    function automatic int fmt(input logic [6:0] op);
        case (op)
            7'h33:               return 0;
            7'h13, 7'h03, 7'h67: return 1;
            7'h23:               return 2;
            7'h63:               return 3;
            7'h37, 7'h17:        return 4;
            7'h6F:               return 5;
            default:             return -1;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input beat_t b);
        logic [31:0] i;
        i = b.imm;
        case (fmt(b.op))
            0: return {b.f7, b.rs2, b.rs1, b.f3, b.rd, b.op};
            1: return {i[11:0], b.rs1, b.f3, b.rd, b.op};
            2: return {i[11:5], b.rs2, b.rs1, b.f3, i[4:0], b.op};
            3: return {i[12], i[10:5], b.rs2, b.rs1, b.f3, i[4:1], i[11], b.op};
            4: return {i[31:12], b.rd, b.op};
            5: return {i[20], i[10:1], i[11], i[19:12], b.rd, b.op};
            default: return 32'h0;
        endcase
    endfunction

    // Builds a beat; stream fields not used by the format carry random junk.
    function automatic beat_t make_beat(input logic [6:0] op, input logic [4:0] brd,
                                        input logic [4:0] brs1, input logic [4:0] brs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
        beat_t b;
        b.op = op; b.rd = brd; b.rs1 = brs1; b.rs2 = brs2; b.f3 = f3; b.f7 = f7; b.imm = imm;
        b.imm12 = 12'($urandom);
        b.imm20 = 20'($urandom);
        case (fmt(op))
            1, 2: b.imm12 = imm[11:0];
            3:    b.imm12 = imm[12:1];
            4:    b.imm20 = imm[31:12];
            5:    b.imm20 = imm[20:1];
            default: ;
        endcase
        return b;
    endfunction

    function automatic beat_t rand_beat(input bit allow_ill);
        logic [6:0] legal_ops [9];
        logic [6:0] op;
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
        if (allow_ill && $urandom_range(0, 7) == 0) begin
            do op = 7'($urandom); while (fmt(op) != -1);
        end else begin
            op = legal_ops[$urandom_range(0, 8)];
        end
        return make_beat(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                         7'($urandom), $urandom);
    endfunction

    task automatic set_inputs(input beat_t b, input bit last);
        start = 1'b0; in_valid = 1'b1; in_last = last;
        opcode = b.op; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
        func3 = b.f3; func7 = b.f7; Imm = b.imm12; Imm20 = b.imm20;
    endtask

    task automatic drive_beat(input beat_t b, input bit last, output bit acc);
        int n = 0;
        @(negedge clk);
        set_inputs(b, last);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        acc = in_ready;
        if (acc) @(posedge clk);
        #1 in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic model_accept(input beat_t b, input bit last);
        logic [31:0] w;
        if (fmt(b.op) < 0) begin
            mill = 1'b1;
        end else begin
            w = ref_word(b);
            wq.push_back('{maddr, w});
            maddr++;
            mcount++;
            mcks ^= w;
        end
        if (last) dq.push_back('{mcount, mill, movf, mcks});
    endtask

    task automatic start_session(input logic [ADDR_W-1:0] base);
        @(negedge clk);
        start = 1'b1; base_addr = base;
        @(posedge clk);
        #1 start = 1'b0;
        maddr = base; mcount = 0; mill = 1'b0; movf = 1'b0; mcks = '0;
        @(negedge clk);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_word_count", 32'(word_count), 32'd0);
        chk("start_err_illegal", 32'(err_illegal), 32'd0);
        chk("start_err_overflow", 32'(err_overflow), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("session_end_busy", 32'(busy), 32'd0);
        #1;
        chk("writes_outstanding", 32'(wq.size()), 32'd0);
        chk("done_outstanding", 32'(dq.size()), 32'd0);
    endtask

    task automatic run_session(input logic [ADDR_W-1:0] base, input int nbeats, input bit use_dir,
                               input bit with_last, input bit gaps, input bit allow_ill);
        beat_t b;
        bit    acc, last;
        start_session(base);
        for (int i = 0; i < nbeats; i++) begin
            b    = use_dir ? dir.pop_front() : rand_beat(allow_ill);
            last = with_last && (i == nbeats - 1);
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    start     = ($urandom_range(0, 3) == 0);
                    base_addr = ADDR_W'($urandom);
                end
            end
            if (mcount < MAX_WORDS) begin
                drive_beat(b, last, acc);
                chk("beat_accepted", 32'(acc), 32'd1);
                if (acc) model_accept(b, last);
                if (last) break;
            end else begin
                @(negedge clk);
                set_inputs(b, 1'b0);
                chk("overflow_stall_ready", 32'(in_ready), 32'd0);
                movf = 1'b1;
                dq.push_back('{mcount, mill, movf, mcks});
                @(posedge clk);
                #1 in_valid = 1'b0;
                break;
            end
        end
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (mem_we) begin
            if (wq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, none expected", mem_addr, mem_wdata);
            end else begin
                mon_w = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(mon_w.addr));
                chk("wr_data", mem_wdata, mon_w.data);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: word_count %0d, none expected", word_count);
            end else begin
                mon_d = dq.pop_front();
                chk("done_word_count", 32'(word_count), 32'(mon_d.wc));
                chk("done_err_illegal", 32'(err_illegal), 32'(mon_d.ill));
                chk("done_err_overflow", 32'(err_overflow), 32'(mon_d.ovf));
`ifdef INST_ENCODER_CHECKSUM_EN
                chk("done_checksum", checksum, mon_d.cks);
`endif
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_err_illegal"}, 32'(err_illegal), 32'd0);
        chk({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        bit    acc;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        // add x3,x1,x2 / addi x5,x0,10 / sw x2,8(x1)
        dir.push_back(make_beat(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, $urandom));
        dir.push_back(make_beat(7'h13, 5'd5, 5'd0, 5'($urandom), 3'd0, 7'($urandom), 32'd10));
        dir.push_back(make_beat(7'h23, 5'($urandom), 5'd1, 5'd2, 3'd2, 7'($urandom), 32'd8));
        run_session(10'h010, 3, 1'b1, 1'b1, 1'b0, 1'b0);

        // beq x1,x2,+8 / jal x1,+16 / lui x5,0x12345
        dir.push_back(make_beat(7'h63, 5'($urandom), 5'd1, 5'd2, 3'd0, 7'($urandom), 32'd8));
        dir.push_back(make_beat(7'h6F, 5'd1, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'd16));
        dir.push_back(make_beat(7'h37, 5'd5, 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), 32'h12345000));
        run_session(10'h123, 3, 1'b1, 1'b1, 1'b1, 1'b0);

        // unsupported opcode between two good beats
        dir.push_back(make_beat(7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10));
        dir.push_back(make_beat(7'h7F, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), $urandom));
        dir.push_back(make_beat(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0));
        run_session(10'h100, 3, 1'b1, 1'b1, 1'b0, 1'b0);

        // session ending on an unsupported opcode
        dir.push_back(make_beat(7'h17, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, $urandom));
        dir.push_back(make_beat(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0));
        run_session(10'h3FF, 2, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int s = 0; s < 6; s++)
            run_session(ADDR_W'($urandom), $urandom_range(1, 30), 1'b0, 1'b1, 1'b1, 1'b1);

        // reset one cycle after an accepted beat: pending write must vanish
        start_session(10'h020);
        b = make_beat(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5);
        drive_beat(b, 1'b0, acc);
        chk("rst_beat_accepted", 32'(acc), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drops_write", 32'(mem_we), 32'd0);
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        run_session(10'h040, 5, 1'b0, 1'b1, 1'b0, 1'b1);

        // fill to MAX_WORDS across the address wrap, then one stalled beat
        run_session(10'h3FE, MAX_WORDS + 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_session(10'h005, 4, 1'b0, 1'b1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
- Inverse of the core's instruction-field decoder: accepts decoded RV32IM fields (opcode, rd, rs1, rs2, func3, func7, Imm, Imm20) over a valid/ready stream.
- Re-packs each beat into a 32-bit instruction word and streams it into instruction memory at consecutive word addresses.
- Used by the boot/program-load path and by benches that build programs from fields rather than hex.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MAX_WORDS, 1024, words accepted per load session; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin session; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address, captured on start.
- in_valid  input  1  field beat valid.
- in_ready  output  1  beat accepted when in_valid & in_ready.
- in_last  input  1  final beat of program.
- opcode  input  7  instruction opcode field.
- rd, rs1, rs2  input  5 each  register fields.
- func3  input  3  func3 field.
- func7  input  7  func7 field.
- Imm  input  12  I/S immediate imm[11:0]; B immediate imm[12:1].
- Imm20  input  20  U immediate imm[31:12]; J immediate imm[20:1].
- mem_we  output  1  imem write strobe.
- mem_addr  output  ADDR_W  imem word address.
- mem_wdata  output  32  encoded instruction.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at session end.
- word_count  output  ADDR_W+1  words written in current/last session.
- err_illegal  output  1  sticky: unsupported opcode seen.
- err_overflow  output  1  sticky: beat offered after MAX_WORDS reached.

Behaviour:
- Reset: state IDLE; in_ready, mem_we, done, busy 0; mem_addr, mem_wdata, word_count 0; err flags 0.
- FSM IDLE→RUN on start.
  - On entry: capture base_addr into write pointer; clear word_count and both err flags.
- RUN: in_ready = 1 while word_count < MAX_WORDS.
  - Accepted beat in cycle N → mem_we = 1 at N+1, with mem_addr = pointer and mem_wdata = encoding (one registered stage).
  - Pointer increments modulo 2**ADDR_W; wrap is silent.
  - word_count increments per written word.
- RUN→DONE when either occurs:
  - an accepted beat has in_last = 1; or
  - word_count reaches MAX_WORDS and in_valid = 1 (sets err_overflow; the beat is not consumed, in_ready stays 0).
- DONE: lasts one cycle; done = 1; last mem_we completes in this cycle; →IDLE.
- Encodings, with fields absent from the format forced to 0:
  - R 0110011: {func7, rs2, rs1, func3, rd, op}.
  - I/load/JALR 0010011 / 0000011 / 1100111: {Imm, rs1, func3, rd, op}.
  - S 0100011: {Imm[11:5], rs2, rs1, func3, Imm[4:0], op}.
  - B 1100011: {Imm[11], Imm[9:4], rs2, rs1, func3, Imm[3:0], Imm[10], op}.
  - U 0110111 / 0010111: {Imm20, rd, op}.
  - J 1101111: {Imm20[19], Imm20[9:0], Imm20[10], Imm20[18:11], rd, op}.
- Any other opcode: beat is consumed, nothing written, pointer/count unchanged, err_illegal set; in_last on that beat still ends the session.
- start during RUN/DONE: ignored.
- rst mid-session: immediate return to reset values; a pending write is dropped.

Optional Feature:
- Macro INST_ENCODER_CHECKSUM_EN.
- When defined: adds output checksum [31:0], the XOR of all mem_wdata written this session.
  - Cleared on session start and on rst.
  - Valid and stable from the done pulse until the next start.
- When undefined: the port and its logic are absent.

Decomposition:
- Shared package rv32_isa_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - loader state enum (IDLE, RUN, DONE).
- Sub-module inst_field_encoder: purely combinational fields→{word, illegal}. It is reusable in benches as a golden model against the decoder.

Test Plan:
- start, base_addr=0x010; beats add x3,x1,x2 / addi x5,x0,10 / sw x2,8(x1) with last on beat 3 → writes 0x002081B3 @0x010, 0x00A00293 @0x011, 0x0020A423 @0x012; done pulse; word_count=3.
- beq x1,x2,+8 (Imm=0x004) then jal x1,+16 (Imm20=0x00008) then lui x5,0x12345 → 0x00208463, 0x010000EF, 0x123452B7.
- opcode 0x7F beat between two valid beats → only 2 writes at consecutive addresses; err_illegal=1; cleared at next start.
- ADDR_W=4, MAX_WORDS=16, base_addr=0xE, 17 beats without last → addresses 0xE, 0xF, 0x0…0xD; 17th beat stalled (in_ready=0); err_overflow=1; done.
- rst asserted the cycle after an accepted beat → no mem_we that cycle; all outputs at reset values; later start works normally.
- With INST_ENCODER_CHECKSUM_EN, first-scenario program → checksum = 0x002081B3 ^ 0x00A00293 ^ 0x0020A423 at done.
